// File: rtl/wave_sel_ctrl.sv
// Waveform-select controller: debounced active-low next/prev buttons step a wave
// index with hold-to-repeat, wrap or saturate at the ends, and a change strobe.
module wave_sel_ctrl #(
    parameter int N_WAVES      = 5,
    parameter int SEL_W        = 3,
    parameter int DEBOUNCE_CYC = 480,
    parameter int REPEAT_DELAY = 24000,
    parameter int REPEAT_RATE  = 4800,
    parameter bit WRAP         = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_next,
    input  logic             key_prev,
    output logic [SEL_W-1:0] wave_sel,
    output logic             sel_changed,
    output logic             sel_dir
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(N_WAVES - 1);
    localparam logic [DB_W-1:0]  DB_END    = DB_W'(DEBOUNCE_CYC);
    localparam logic [TMR_W-1:0] DELAY_END = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_END  = TMR_W'(REPEAT_RATE - 1);

    if (((2 ** SEL_W) < N_WAVES) || (N_WAVES < 2) || (DEBOUNCE_CYC < 1) ||
        (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_param_check
        $error("wave_sel_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_t;

    // Bit 0 is the next key, bit 1 the prev key; all levels are active-low.
    logic [1:0]       key_raw;
    logic [1:0]       sync_p0, sync_p1;
    logic [1:0]       db_lvl, db_lvl_d;
    logic [DB_W-1:0]  db_cnt [2];
    logic [1:0]       prs_ev, rel_ev;

    state_t           state, state_nxt;
    logic             own_up, own_up_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             own_rel, other_prs;
    logic             do_step, do_clear, step_up;
    logic [SEL_W:0]   step_res;
    logic [SEL_W-1:0] sel_nxt;
    logic             chg_nxt, dir_nxt;

    // Returns {changed, new index}; a blocked step at an end reports no change.
    function automatic logic [SEL_W:0] step_index(input logic [SEL_W-1:0] cur,
                                                  input logic up);
        logic [SEL_W-1:0] nxt;
        logic             chg;
        nxt = cur;
        chg = 1'b1;
        if (up) begin
            if (cur != SEL_MAX) nxt = cur + 1'b1;
            else if (WRAP)      nxt = '0;
            else                chg = 1'b0;
        end else begin
            if (cur != '0)      nxt = cur - 1'b1;
            else if (WRAP)      nxt = SEL_MAX;
            else                chg = 1'b0;
        end
        return {chg, nxt};
    endfunction

    assign key_raw = {key_prev, key_next};

    // Synchroniser and debouncer stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= 2'b11;
            sync_p1   <= 2'b11;
            db_lvl    <= 2'b11;
            db_lvl_d  <= 2'b11;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_p0  <= key_raw;
            sync_p1  <= sync_p0;
            db_lvl_d <= db_lvl;
            for (int k = 0; k < 2; k++) begin
                if (sync_p1[k] == db_lvl[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_END) begin
                    db_lvl[k] <= sync_p1[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign prs_ev    = db_lvl_d & ~db_lvl;
    assign rel_ev    = ~db_lvl_d & db_lvl;
    assign own_rel   = own_up ? rel_ev[0] : rel_ev[1];
    assign other_prs = own_up ? prs_ev[1] : prs_ev[0];

    // Stepping FSM; release is tested before timer expiry so it always wins
    always_comb begin
        state_nxt  = state;
        own_up_nxt = own_up;
        timer_nxt  = '0;
        do_step    = 1'b0;
        do_clear   = 1'b0;
        step_up    = own_up;
        case (state)
            S_IDLE: begin
                if (prs_ev == 2'b11) begin
                    do_clear  = 1'b1;
                    state_nxt = S_LOCK;
                end else if (prs_ev != 2'b00) begin
                    do_step    = 1'b1;
                    step_up    = prs_ev[0];
                    own_up_nxt = prs_ev[0];
                    state_nxt  = S_DELAY;
                end
            end
            S_DELAY: begin
                if (own_rel) begin
                    state_nxt = S_IDLE;
                end else if (other_prs) begin
                    state_nxt = S_LOCK;
                end else if (timer == DELAY_END) begin
                    do_step   = 1'b1;
                    state_nxt = S_REPEAT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_REPEAT: begin
                if (own_rel) begin
                    state_nxt = S_IDLE;
                end else if (other_prs) begin
                    state_nxt = S_LOCK;
                end else if (timer == RATE_END) begin
                    do_step = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_LOCK: begin
                if (db_lvl == 2'b11) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        step_res = step_index(wave_sel, step_up);
        sel_nxt  = wave_sel;
        chg_nxt  = 1'b0;
        dir_nxt  = sel_dir;
        if (do_clear) begin
            sel_nxt = '0;
            if (wave_sel != '0) begin
                chg_nxt = 1'b1;
                dir_nxt = 1'b0;
            end
        end else if (do_step && step_res[SEL_W]) begin
            sel_nxt = step_res[SEL_W-1:0];
            chg_nxt = 1'b1;
            dir_nxt = step_up;
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            own_up      <= 1'b1;
            timer       <= '0;
            wave_sel    <= '0;
            sel_changed <= 1'b0;
            sel_dir     <= 1'b1;
        end else begin
            state       <= state_nxt;
            own_up      <= own_up_nxt;
            timer       <= timer_nxt;
            wave_sel    <= sel_nxt;
            sel_changed <= chg_nxt;
            sel_dir     <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Directed bench for wave_sel_ctrl: a wrapping and a saturating instance with
// short debounce/repeat timing, checked against hand-derived edge counts.
`timescale 1ns/1ps
module tb_wave_sel_ctrl;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys  = 4'hF;   // [0] next/[1] prev of wrap dut, [2]/[3] of sat dut
    logic [2:0] sel_m, sel_s;
    logic       chg_m, chg_s, dir_m, dir_s;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         pc_m   = 0;
    int         pc_s   = 0;

    always #5 clk = ~clk;

    wave_sel_ctrl #(.N_WAVES(5), .SEL_W(3), .DEBOUNCE_CYC(4), .REPEAT_DELAY(20),
                    .REPEAT_RATE(5), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .key_next(keys[0]), .key_prev(keys[1]),
        .wave_sel(sel_m), .sel_changed(chg_m), .sel_dir(dir_m));

    wave_sel_ctrl #(.N_WAVES(5), .SEL_W(3), .DEBOUNCE_CYC(4), .REPEAT_DELAY(20),
                    .REPEAT_RATE(5), .WRAP(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .key_next(keys[2]), .key_prev(keys[3]),
        .wave_sel(sel_s), .sel_changed(chg_s), .sel_dir(dir_s));

    always @(negedge clk) begin
        if (chg_m) pc_m++;
        if (chg_s) pc_s++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        keys[idx] = 1'b0;
        repeat (10) cyc();
        keys[idx] = 1'b1;
        repeat (10) cyc();
    endtask

    initial begin
        int base;
        int k;
        bit exp_p;

        // reset state, then five clean next presses with wrap
        repeat (3) cyc();
        chk("rst_sel", int'(sel_m), 0);
        chk("rst_chg", int'(chg_m), 0);
        chk("rst_dir", int'(dir_m), 1);
        chk("rst_sat_sel", int'(sel_s), 0);
        reset = 1'b0;
        repeat (3) cyc();
        for (int i = 1; i <= 5; i++) begin
            base = pc_m;
            press(0);
            chk("t1_sel", int'(sel_m), i % 5);
            chk("t1_pulse", pc_m - base, 1);
            chk("t1_dir", int'(dir_m), 1);
        end

        // bounce rejected; 8-cycle press steps exactly at edge N+7
        base = pc_m;
        keys[0] = 1'b0;
        repeat (3) cyc();
        keys[0] = 1'b1;
        repeat (15) cyc();
        chk("t2_bounce_sel", int'(sel_m), 0);
        chk("t2_bounce_pulse", pc_m - base, 0);
        keys[0] = 1'b0;
        repeat (7) cyc();
        chk("t2_pre_step", int'(sel_m), 0);
        cyc();
        chk("t2_step_sel", int'(sel_m), 1);
        chk("t2_step_chg", int'(chg_m), 1);
        keys[0] = 1'b1;
        repeat (15) cyc();
        chk("t2_one_pulse", pc_m - base, 1);

        // auto-repeat: steps at +0,+20,+25,...; release at +60 lands at +67, so +65 still steps
        press(1);
        chk("t3_start", int'(sel_m), 0);
        base = pc_m;
        keys[0] = 1'b0;
        repeat (8) cyc();
        chk("t3_first", int'(sel_m), 1);
        chk("t3_first_chg", int'(chg_m), 1);
        k = 1;
        for (int off = 1; off <= 70; off++) begin
            cyc();
            exp_p = (off >= 20) && (off <= 65) && (off % 5 == 0);
            chk($sformatf("t3_pulse_at_%0d", off), int'(chg_m), int'(exp_p));
            if (exp_p) begin
                k++;
                chk("t3_rep_sel", int'(sel_m), k % 5);
            end
            if (off == 60) keys[0] = 1'b1;
        end
        repeat (10) cyc();
        chk("t3_final_sel", int'(sel_m), 1);
        chk("t3_total", pc_m - base, 11);

        // ends: wrap down from 0, saturate at 0 and at 4
        press(1);
        chk("t4_at0", int'(sel_m), 0);
        base = pc_m;
        press(1);
        chk("t4_wrap_sel", int'(sel_m), 4);
        chk("t4_wrap_dir", int'(dir_m), 0);
        chk("t4_wrap_pulse", pc_m - base, 1);
        base = pc_s;
        press(3);
        chk("t4_sat_sel", int'(sel_s), 0);
        chk("t4_sat_pulse", pc_s - base, 0);
        chk("t4_sat_dir", int'(dir_s), 1);
        for (int i = 0; i < 3; i++) press(2);
        chk("t4_sat_at3", int'(sel_s), 3);
        base = pc_s;
        keys[2] = 1'b0;
        repeat (8) cyc();
        chk("t4_sat_top", int'(sel_s), 4);
        repeat (50) cyc();
        keys[2] = 1'b1;
        repeat (15) cyc();
        chk("t4_sat_hold_sel", int'(sel_s), 4);
        chk("t4_sat_hold_pulse", pc_s - base, 1);

        // both keys together clear to 0 and lock until both are released
        for (int i = 0; i < 4; i++) press(0);
        chk("t5_at3", int'(sel_m), 3);
        chk("t5_dir_up", int'(dir_m), 1);
        base = pc_m;
        keys[1:0] = 2'b00;
        repeat (8) cyc();
        chk("t5_both_sel", int'(sel_m), 0);
        chk("t5_both_chg", int'(chg_m), 1);
        chk("t5_both_dir", int'(dir_m), 0);
        keys[0] = 1'b1;
        repeat (10) cyc();
        press(0);
        press(0);
        chk("t5_lock_sel", int'(sel_m), 0);
        chk("t5_lock_pulse", pc_m - base, 1);
        keys[1] = 1'b1;
        repeat (15) cyc();
        press(0);
        chk("t5_unlock_sel", int'(sel_m), 1);

        // asynchronous reset in REPEAT, key held through release
        press(1);
        chk("t6_at0", int'(sel_m), 0);
        keys[0] = 1'b0;
        repeat (8) cyc();
        chk("t6_first", int'(sel_m), 1);
        repeat (22) cyc();
        chk("t6_repeat", int'(sel_m), 2);
        reset = 1'b1;
        #2;
        chk("t6_async_sel", int'(sel_m), 0);
        chk("t6_async_chg", int'(chg_m), 0);
        chk("t6_async_dir", int'(dir_m), 1);
        chk("t6_async_sat", int'(sel_s), 0);
        cyc();
        reset = 1'b0;
        repeat (7) cyc();
        chk("t6_pre", int'(sel_m), 0);
        cyc();
        chk("t6_step_sel", int'(sel_m), 1);
        chk("t6_step_chg", int'(chg_m), 1);
        repeat (19) cyc();
        chk("t6_rep_pre", int'(sel_m), 1);
        cyc();
        chk("t6_rep_sel", int'(sel_m), 2);
        keys[0] = 1'b1;
        repeat (15) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
